// File: rtl/userkey_pkg.sv
// Shared definitions for the user-key controller: register map and decode width.
package userkey_pkg;

    // Number of address bits decoded to select a register (addr[3:2])
    localparam int ADDR_DEC_W = 2;

    // Register offsets within the decoded word address
    localparam logic [ADDR_DEC_W-1:0] REG_STATE    = 2'd0;
    localparam logic [ADDR_DEC_W-1:0] REG_PEND     = 2'd1;
    localparam logic [ADDR_DEC_W-1:0] REG_PRESS_EN = 2'd2;
    localparam logic [ADDR_DEC_W-1:0] REG_REL_EN   = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, debounce counter, stable state and
// single-cycle registered press/release pulses on each stable-state change.
module key_debounce #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic key_raw,
    output logic key_stable,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0]       sync_r;
    logic             pressed_s;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;
    logic             release_r;

    // Pin is active-low; the debouncer works on "pressed" polarity
    assign pressed_s = ~sync_r[1];

    // Synchronize the raw pin; reset to the released level so no false press appears
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], key_raw};
        end
    end

    // Debounce: count consecutive cycles of disagreement, commit after the window
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stable_r  <= 1'b0;
            cnt_r     <= CNT_ZERO;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            if (pressed_s == stable_r) begin
                // Agreement (or a bounce back) discards any partial count
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                stable_r  <= pressed_s;
                cnt_r     <= CNT_ZERO;
                press_r   <= pressed_s;
                release_r <= ~pressed_s;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign key_stable  = stable_r;
    assign key_press   = press_r;
    assign key_release = release_r;

endmodule

// File: rtl/userkey_ctrl.sv
// User-key controller top: per-key debouncers, register file (STATE, PEND,
// PRESS_EN, REL_EN), edge-to-pending logic, read mux and interrupt.
module userkey_ctrl
    import userkey_pkg::*;
#(
    parameter int N_KEYS    = 8,
    parameter int DB_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [N_KEYS-1:0] user_key,
    input  logic [3:0]        addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       userkey_rd,
    output logic              userkey_int
);

    logic [N_KEYS-1:0]     stable_s;
    logic [N_KEYS-1:0]     press_s;
    logic [N_KEYS-1:0]     release_s;
    logic [N_KEYS-1:0]     pend_r;
    logic [N_KEYS-1:0]     press_en_r;
    logic [N_KEYS-1:0]     rel_en_r;
    logic [N_KEYS-1:0]     pend_next_s;
    logic [N_KEYS-1:0]     w1c_mask_s;
    logic [N_KEYS-1:0]     rd_field_s;
    logic [ADDR_DEC_W-1:0] reg_sel_s;
    logic                  unused_s;

    assign reg_sel_s = addr[3:2];
    // Byte-lane bits and write-data bits above N_KEYS carry no meaning here
    assign unused_s  = ^{addr[1:0], wdata};

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_debounce (
                .clk         (clk),
                .clr_n       (clr_n),
                .key_raw     (user_key[gi]),
                .key_stable  (stable_s[gi]),
                .key_press   (press_s[gi]),
                .key_release (release_s[gi])
            );
        end
    endgenerate

    // Pending next state: W1C mask applied first, enabled edges ORed after so a set wins
    always_comb begin
        w1c_mask_s = {N_KEYS{1'b0}};
        if (we && (reg_sel_s == REG_PEND)) begin
            w1c_mask_s = wdata[N_KEYS-1:0];
        end else begin
            w1c_mask_s = {N_KEYS{1'b0}};
        end
        pend_next_s = (pend_r & ~w1c_mask_s) | (press_s & press_en_r) | (release_s & rel_en_r);
    end

    // Register file: pending bits and the two edge-enable registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_r     <= {N_KEYS{1'b0}};
            press_en_r <= {N_KEYS{1'b0}};
            rel_en_r   <= {N_KEYS{1'b0}};
        end else begin
            pend_r <= pend_next_s;
            if (we && (reg_sel_s == REG_PRESS_EN)) begin
                press_en_r <= wdata[N_KEYS-1:0];
            end else begin
                press_en_r <= press_en_r;
            end
            if (we && (reg_sel_s == REG_REL_EN)) begin
                rel_en_r <= wdata[N_KEYS-1:0];
            end else begin
                rel_en_r <= rel_en_r;
            end
        end
    end

    // Read mux: selected register zero-extended to the 32-bit bus
    always_comb begin
        rd_field_s = {N_KEYS{1'b0}};
        case (reg_sel_s)
            REG_STATE:    rd_field_s = stable_s;
            REG_PEND:     rd_field_s = pend_r;
            REG_PRESS_EN: rd_field_s = press_en_r;
            REG_REL_EN:   rd_field_s = rel_en_r;
            default:      rd_field_s = {N_KEYS{1'b0}};
        endcase
        userkey_rd = 32'd0;
        userkey_rd[N_KEYS-1:0] = rd_field_s;
    end

    // Interrupt is a pure OR of flops, so it cannot glitch from decode logic
    assign userkey_int = |pend_r;

endmodule

// File: tb/tb_userkey_ctrl.sv
// Self-checking bench for userkey_ctrl (N_KEYS=8, DB_CYCLES=4): behavioural
// model compared every cycle, plus directed literal expectations.
module tb_userkey_ctrl;

    localparam int NK = 8;
    localparam int DB = 4;

    logic        clk;
    logic        clr_n;
    logic [7:0]  user_key;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] userkey_rd;
    logic        userkey_int;

    int n_checks = 0;
    int n_errors = 0;

    userkey_ctrl #(
        .N_KEYS    (NK),
        .DB_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .user_key    (user_key),
        .addr        (addr),
        .we          (we),
        .wdata       (wdata),
        .userkey_rd  (userkey_rd),
        .userkey_int (userkey_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A key's stable state flips once the last DB synchronized samples all
    // disagree with it; PEND picks up enabled flips one cycle later.
    logic [7:0]    m_s1, m_s2, m_stable, m_pend, m_pen, m_ren, m_evp, m_evr;
    logic [DB-1:0] m_hist [NK];

    always @(posedge clk or negedge clr_n) begin : model
        logic [7:0]    clr_v, st_v, evp_v, evr_v;
        logic [DB-1:0] h_v;
        if (!clr_n) begin
            m_s1 <= 8'hFF; m_s2 <= 8'hFF; m_stable <= 8'h00; m_pend <= 8'h00;
            m_pen <= 8'h00; m_ren <= 8'h00; m_evp <= 8'h00; m_evr <= 8'h00;
            for (int k = 0; k < NK; k++) m_hist[k] <= '0;
        end else begin
            clr_v = (we && addr[3:2] == 2'd1) ? wdata[7:0] : 8'h00;
            m_pend <= (m_pend & ~clr_v) | (m_evp & m_pen) | (m_evr & m_ren);
            if (we && addr[3:2] == 2'd2) m_pen <= wdata[7:0];
            if (we && addr[3:2] == 2'd3) m_ren <= wdata[7:0];
            m_s1 <= user_key;
            m_s2 <= m_s1;
            st_v = m_stable; evp_v = 8'h00; evr_v = 8'h00;
            for (int k = 0; k < NK; k++) begin
                h_v = {m_hist[k][DB-2:0], ~m_s2[k]};
                if (h_v == {DB{~m_stable[k]}}) begin
                    st_v[k] = ~m_stable[k];
                    if (st_v[k]) evp_v[k] = 1'b1;
                    else         evr_v[k] = 1'b1;
                end
                m_hist[k] <= h_v;
            end
            m_stable <= st_v;
            m_evp    <= evp_v;
            m_evr    <= evr_v;
        end
    end

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {24'h0, m_stable};
            2'd1:    return {24'h0, m_pend};
            2'd2:    return {24'h0, m_pen};
            default: return {24'h0, m_ren};
        endcase
    endfunction

    // Every-cycle comparison just after the active edge
    initial begin : compare
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            chk("cyc_rd", userkey_rd, model_rd(addr));
            chk("cyc_int", {31'd0, userkey_int}, {31'd0, |m_pend});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; we = 1'b1; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, userkey_rd, exp);
    endtask

    initial begin : stim
        clr_n = 1'b0; user_key = 8'hFF; addr = 4'h0; we = 1'b0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;

        // Reset state: all registers zero, no interrupt
        @(negedge clk);
        rd_chk("rst_state", 4'h0, 32'h0);
        rd_chk("rst_pend", 4'h4, 32'h0);
        rd_chk("rst_pen", 4'h8, 32'h0);
        rd_chk("rst_ren", 4'hC, 32'h0);
        chk("rst_int", {31'd0, userkey_int}, 32'd0);

        // Short bounce on key 3 with all edges enabled: nothing happens
        wr(4'h8, 32'h0000_00FF);
        wr(4'hC, 32'h0000_00FF);
        user_key[3] = 1'b0;
        repeat (3) @(negedge clk);
        user_key[3] = 1'b1;
        repeat (8) @(negedge clk);
        rd_chk("bounce_state", 4'h0, 32'h0);
        rd_chk("bounce_pend", 4'h4, 32'h0);

        // Clean press of key 0: STATE after 6 cycles, PEND/int one cycle later
        wr(4'h8, 32'h0000_0001);
        wr(4'hC, 32'h0000_0000);
        user_key[0] = 1'b0;
        addr = 4'h0;
        repeat (5) @(negedge clk);
        rd_chk("press_state_c5", 4'h0, 32'h0);
        @(negedge clk);
        rd_chk("press_state_c6", 4'h0, 32'h1);
        rd_chk("press_pend_c6", 4'h4, 32'h0);
        @(negedge clk);
        rd_chk("press_pend_c7", 4'h4, 32'h1);
        chk("press_int_c7", {31'd0, userkey_int}, 32'd1);

        // Release event of key 0 coinciding with a W1C of the same bit: set wins
        wr(4'hC, 32'h0000_0001);
        user_key[0] = 1'b1;
        repeat (5) @(negedge clk);
        @(negedge clk);
        addr = 4'h4; we = 1'b1; wdata = 32'h0000_0001;
        @(negedge clk);
        we = 1'b0;
        rd_chk("w1c_race_pend", 4'h4, 32'h1);
        chk("w1c_race_int", {31'd0, userkey_int}, 32'd1);
        wr(4'h4, 32'h0000_0001);
        rd_chk("w1c_pend", 4'h4, 32'h0);
        chk("w1c_int", {31'd0, userkey_int}, 32'd0);

        // Simultaneous press of keys 2 and 5; partial W1C leaves key 5 pending
        wr(4'h8, 32'h0000_0024);
        user_key[2] = 1'b0; user_key[5] = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk("multi_state", 4'h0, 32'h24);
        rd_chk("multi_pend_c6", 4'h4, 32'h0);
        @(negedge clk);
        rd_chk("multi_pend_c7", 4'h4, 32'h24);
        wr(4'h4, 32'hFFFF_FF04);
        rd_chk("multi_w1c_pend", 4'h4, 32'h20);
        chk("multi_w1c_int", {31'd0, userkey_int}, 32'd1);
        wr(4'h0, 32'hFFFF_FFFF);
        rd_chk("state_ro", 4'h0, 32'h24);

        // Release keys 2/5 (release edges disabled there), then reset mid-window on key 1
        user_key[2] = 1'b1; user_key[5] = 1'b1;
        repeat (10) @(negedge clk);
        rd_chk("relq_pend", 4'h4, 32'h20);
        user_key[1] = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        rd_chk("mid_rst_state", 4'h0, 32'h0);
        clr_n = 1'b1;
        repeat (5) @(negedge clk);
        rd_chk("post_rst_c5", 4'h0, 32'h0);
        @(negedge clk);
        rd_chk("post_rst_c6", 4'h0, 32'h2);
        @(negedge clk);
        rd_chk("post_rst_pend", 4'h4, 32'h0);
        rd_chk("post_rst_pen", 4'h8, 32'h0);
        chk("post_rst_int", {31'd0, userkey_int}, 32'd0);

        // Randomized traffic checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NK; i++) begin
                if ($urandom_range(0, 9) == 0) user_key[i] = ~user_key[i];
            end
            we    = ($urandom_range(0, 3) == 0);
            addr  = 4'($urandom_range(0, 15));
            wdata = $urandom;
        end
        @(negedge clk);
        we = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/userkey_ctrl.md
USERKEY_CTRL -- requirements
Module: userkey_ctrl

Interface
REQ-001 Parameter N_KEYS, default 8: number of key channels, legal range 1..32.
REQ-002 Parameter DB_CYCLES, default 20000: debounce stability window in clk cycles, minimum 1.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 clr_n  input  1  reset, asynchronous assert, active-low.
REQ-005 user_key  input  N_KEYS  raw key pins, active-low (0 = pressed), asynchronous to clk.
REQ-006 addr  input  4  byte address of register; only addr[3:2] decoded.
REQ-007 we  input  1  write strobe, single-cycle.
REQ-008 wdata  input  32  write data.
REQ-009 userkey_rd  output  32  read data; combinational from addr and registers.
REQ-010 userkey_int  output  1  interrupt request, active-high level.

Function
REQ-011 Each user_key bit shall pass through a 2-flop synchronizer before any other use.
REQ-012 Per channel, a stable state bit (1 = pressed, i.e. inverted synchronized pin) and a debounce counter of width $clog2(DB_CYCLES+1) shall be kept.
REQ-013 While the synchronized inverted pin equals the stable bit, the counter shall hold 0.
REQ-014 While they differ, the counter shall increment each cycle; when it reaches DB_CYCLES-1 the stable bit shall take the new value and the counter shall return to 0.
REQ-015 A pin bounce back to the stable value before the window completes shall clear the counter with no stable-bit change.
REQ-016 Latency, raw pin change to stable-bit change: 2 + DB_CYCLES cycles for a clean transition.
REQ-017 Register map (addr[3:2]): 0 STATE RO = stable bits; 1 PEND = pending bits, write-1-to-clear; 2 PRESS_EN RW; 3 REL_EN RW; bits above N_KEYS read 0, writes to them ignored.
REQ-018 A 0->1 stable-bit change on channel k shall set PEND[k] in the following cycle when PRESS_EN[k] = 1; a 1->0 change likewise when REL_EN[k] = 1.
REQ-019 Disabled edges shall not set PEND; enabling an edge shall not retroactively set PEND.
REQ-020 A PEND set event and a W1C of the same bit in the same cycle: set wins, bit remains 1.
REQ-021 Writes to STATE shall have no effect.
REQ-022 userkey_int = OR of all PEND bits, driven directly from registered state (glitch-free).
REQ-023 Channels shall be fully independent; simultaneous events on several channels shall all be captured.

Reset
REQ-024 On clr_n = 0: synchronizer flops = 1 (released), stable bits = 0, counters = 0, PEND = 0, PRESS_EN = 0, REL_EN = 0, userkey_int = 0.
REQ-025 A reset asserted mid-debounce shall discard the partial count; after release no edge event shall be generated for keys already held, until the window completes, which then produces a press event.
REQ-026 Reset release shall be synchronized externally; the block need not tolerate a release within recovery time.

Structure
REQ-027 A shared package shall hold the register offsets (STATE, PEND, PRESS_EN, REL_EN) and the address-decode width.
REQ-028 One sub-module key_debounce (synchronizer, counter, stable bit, press/release pulses) shall be instantiated N_KEYS times via generate.
REQ-029 Top level shall contain only the register file, edge-to-pending logic and read mux.

Verification (bench uses N_KEYS=8, DB_CYCLES=4)
REQ-030 Reset, then read all four registers -> all read 0x00000000, userkey_int = 0.
REQ-031 PRESS_EN=0x01, drive user_key[0]=0 clean -> STATE=0x01 exactly 6 cycles later, PEND=0x01 and userkey_int=1 one cycle after that.
REQ-032 Toggle user_key[3] low for 3 cycles then high, REL_EN=PRESS_EN=0xFF -> STATE and PEND stay 0x00.
REQ-033 PEND=0x01, write PEND 0x01 in the same cycle as a new key0 release event with REL_EN=0x01 -> PEND stays 0x01; a later lone write 0x01 -> PEND=0x00, userkey_int=0.
REQ-034 Press keys 2 and 5 in the same cycle, PRESS_EN=0x24 -> PEND=0x24 in one cycle; write 0xFFFFFF04 to PEND -> PEND=0x20, userkey_int stays 1.
REQ-035 Hold user_key[1]=0, pulse clr_n low mid-window -> STATE=0x00 after reset, STATE=0x02 at 6 cycles after release, PEND=0x00 because enables reset to 0.
